// File: rtl/tlb_op_ctrl_pkg.sv
// TLB instruction controller shared types: op codes, FSM states,
// 78-bit TLB entry layout and its field offsets.
package tlb_op_ctrl_pkg;

  localparam int TLBNUM_DEF = 16;
  localparam int IDXW_DEF   = 4;
  localparam int ENTRY_W    = 78;

  localparam int V1_BIT   = 0;
  localparam int D1_BIT   = 1;
  localparam int C1_LSB   = 2;
  localparam int PFN1_LSB = 5;
  localparam int V0_BIT   = 25;
  localparam int D0_BIT   = 26;
  localparam int C0_LSB   = 27;
  localparam int PFN0_LSB = 30;
  localparam int G_BIT    = 50;
  localparam int ASID_LSB = 51;
  localparam int VPN2_LSB = 59;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_TLBP  = 2'b01,
    OP_TLBR  = 2'b10,
    OP_TLBWI = 2'b11
  } tlb_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_COMMIT,
    S_CANCEL
  } state_e;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

endpackage

// File: rtl/tlb_entry_pack.sv
// Packs CP0 EntryHi/EntryLo0/EntryLo1 into one 78-bit TLB entry.
// Ports: entryhi, lo0, lo1 (32b each) in; entry (78b) out.
module tlb_entry_pack
  import tlb_op_ctrl_pkg::*;
(
  input  logic [31:0]        entryhi,
  input  logic [31:0]        lo0,
  input  logic [31:0]        lo1,
  output logic [ENTRY_W-1:0] entry
);

  tlb_entry_t e;

  always_comb begin
    e.vpn2 = entryhi[31:13];
    e.asid = entryhi[7:0];
    e.g    = lo0[0] & lo1[0];
    e.pfn0 = lo0[25:6];
    e.c0   = lo0[5:3];
    e.d0   = lo0[2];
    e.v0   = lo0[1];
    e.pfn1 = lo1[25:6];
    e.c1   = lo1[5:3];
    e.d1   = lo1[2];
    e.v1   = lo1[1];
  end

  assign entry = e;

  logic unused_bits;
  assign unused_bits = ^{entryhi[12:8], lo0[31:26], lo1[31:26]};

endmodule

// File: rtl/tlb_op_ctrl.sv
// Sequences TLBP/TLBR/TLBWI from WB: EXEC -> COMMIT -> (CANCEL).
// Ports: WB req/flush, CP0 regs, TLB search/read/write, CP0 results, refetch.
module tlb_op_ctrl
  import tlb_op_ctrl_pkg::*;
#(
  parameter int TLBNUM = TLBNUM_DEF,
  parameter int IDXW   = $clog2(TLBNUM)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               req_valid,
  input  logic [1:0]         req_op,
  input  logic [31:0]        req_pc,
  output logic               req_ready,
  input  logic               flush,
  input  logic [31:0]        cp0_index,
  input  logic [31:0]        cp0_entryhi,
  input  logic [31:0]        cp0_entrylo0,
  input  logic [31:0]        cp0_entrylo1,
  output logic [18:0]        s1_vpn2,
  output logic [7:0]         s1_asid,
  input  logic               s1_found,
  input  logic [IDXW-1:0]    s1_index,
  output logic [IDXW-1:0]    tlb_r_index,
  input  logic [ENTRY_W-1:0] tlb_r_entry,
  output logic               tlb_we,
  output logic [IDXW-1:0]    tlb_w_index,
  output logic [ENTRY_W-1:0] tlb_w_entry,
  output logic               cp0_tlbp_we,
  output logic               cp0_tlbp_p,
  output logic [IDXW-1:0]    cp0_tlbp_index,
  output logic               cp0_tlbr_we,
  output logic [ENTRY_W-1:0] cp0_tlbr_data,
  output logic               cancel,
  output logic [31:0]        cancel_pc,
  output logic               busy
);

  state_e  state_q, state_d;
  tlb_op_e op_q;

  logic [31:0]        pc4_q;
  logic [31:0]        idx_q;
  logic [31:0]        hi_q;
  logic [31:0]        lo0_q;
  logic [31:0]        lo1_q;
  logic               p_q;
  logic [IDXW-1:0]    pidx_q;
  logic [ENTRY_W-1:0] rd_q;
  logic               accept;
  logic               exec_ok;

  assign req_ready = (state_q == S_IDLE) && !flush;
  assign accept    = req_valid && req_ready && (req_op != OP_NONE);
  assign exec_ok   = (state_q == S_EXEC) && !flush;

  always_comb begin
    state_d     = state_q;
    tlb_we      = 1'b0;
    cp0_tlbp_we = 1'b0;
    cp0_tlbr_we = 1'b0;
    cancel      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_EXEC;
      end
      S_EXEC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          tlb_we  = (op_q == OP_TLBWI);
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          cp0_tlbp_we = (op_q == OP_TLBP);
          cp0_tlbr_we = (op_q == OP_TLBR);
          state_d = (op_q == OP_TLBP) ? S_IDLE : S_CANCEL;
        end
      end
      S_CANCEL: begin
        cancel  = !flush;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // pc+4 is stored so cancel_pc is a plain register (zero at reset)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q  <= OP_NONE;
      pc4_q <= '0;
      idx_q <= '0;
      hi_q  <= '0;
      lo0_q <= '0;
      lo1_q <= '0;
    end else if (accept) begin
      op_q  <= tlb_op_e'(req_op);
      pc4_q <= req_pc + 32'd4;
      idx_q <= cp0_index;
      hi_q  <= cp0_entryhi;
      lo0_q <= cp0_entrylo0;
      lo1_q <= cp0_entrylo1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      p_q    <= 1'b0;
      pidx_q <= '0;
      rd_q   <= '0;
    end else if (exec_ok) begin
      if (op_q == OP_TLBP) begin
        p_q    <= !s1_found;
        pidx_q <= s1_found ? s1_index : '0;
      end
      if (op_q == OP_TLBR) rd_q <= tlb_r_entry;
    end
  end

  tlb_entry_pack u_pack (
    .entryhi (hi_q),
    .lo0     (lo0_q),
    .lo1     (lo1_q),
    .entry   (tlb_w_entry)
  );

  assign s1_vpn2        = hi_q[31:13];
  assign s1_asid        = hi_q[7:0];
  assign tlb_r_index    = idx_q[IDXW-1:0];
  assign tlb_w_index    = idx_q[IDXW-1:0];
  assign cp0_tlbp_p     = p_q;
  assign cp0_tlbp_index = pidx_q;
  assign cp0_tlbr_data  = rd_q;
  assign cancel_pc      = pc4_q;
  assign busy           = (state_q != S_IDLE);

  logic unused_idx;
  assign unused_idx = ^idx_q[31:IDXW];

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl: TLBWI/TLBP/TLBR flows,
// flush abort, mid-op reset and cancel_pc wraparound.
module tb_tlb_op_ctrl;

  localparam int IDXW = 4;
  localparam logic [77:0] PAT = 78'h2A5A_5A5A_5A5A_5A5A_5A5A;
  localparam logic [77:0] W1 =
    {19'h201, 8'h12, 1'b1, 20'h41, 3'd0, 1'b1, 1'b1,
     20'h42, 3'd0, 1'b1, 1'b1};
  localparam logic [77:0] W2 =
    {19'h7FFFF, 8'hFF, 1'b0, 20'hFFFFF, 3'd7, 1'b1, 1'b0,
     20'h0, 3'd5, 1'b0, 1'b1};

  logic            clk = 1'b0;
  logic            resetn;
  logic            req_valid;
  logic [1:0]      req_op;
  logic [31:0]     req_pc;
  logic            req_ready;
  logic            flush;
  logic [31:0]     cp0_index;
  logic [31:0]     cp0_entryhi;
  logic [31:0]     cp0_entrylo0;
  logic [31:0]     cp0_entrylo1;
  logic [18:0]     s1_vpn2;
  logic [7:0]      s1_asid;
  logic            s1_found;
  logic [IDXW-1:0] s1_index;
  logic [IDXW-1:0] tlb_r_index;
  logic [77:0]     tlb_r_entry;
  logic            tlb_we;
  logic [IDXW-1:0] tlb_w_index;
  logic [77:0]     tlb_w_entry;
  logic            cp0_tlbp_we;
  logic            cp0_tlbp_p;
  logic [IDXW-1:0] cp0_tlbp_index;
  logic            cp0_tlbr_we;
  logic [77:0]     cp0_tlbr_data;
  logic            cancel;
  logic [31:0]     cancel_pc;
  logic            busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // small TLB model: only entry 3 holds data
  assign tlb_r_entry = (tlb_r_index == 4'd3) ? PAT : '0;

  tlb_op_ctrl dut (
    .clk            (clk),
    .resetn         (resetn),
    .req_valid      (req_valid),
    .req_op         (req_op),
    .req_pc         (req_pc),
    .req_ready      (req_ready),
    .flush          (flush),
    .cp0_index      (cp0_index),
    .cp0_entryhi    (cp0_entryhi),
    .cp0_entrylo0   (cp0_entrylo0),
    .cp0_entrylo1   (cp0_entrylo1),
    .s1_vpn2        (s1_vpn2),
    .s1_asid        (s1_asid),
    .s1_found       (s1_found),
    .s1_index       (s1_index),
    .tlb_r_index    (tlb_r_index),
    .tlb_r_entry    (tlb_r_entry),
    .tlb_we         (tlb_we),
    .tlb_w_index    (tlb_w_index),
    .tlb_w_entry    (tlb_w_entry),
    .cp0_tlbp_we    (cp0_tlbp_we),
    .cp0_tlbp_p     (cp0_tlbp_p),
    .cp0_tlbp_index (cp0_tlbp_index),
    .cp0_tlbr_we    (cp0_tlbr_we),
    .cp0_tlbr_data  (cp0_tlbr_data),
    .cancel         (cancel),
    .cancel_pc      (cancel_pc),
    .busy           (busy)
  );

  task automatic chk(input string tag, input logic [77:0] obs,
                     input logic [77:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] pc);
    req_valid = 1'b1;
    req_op    = op;
    req_pc    = pc;
    #1;
  endtask

  task automatic scramble();
    req_valid    = 1'b0;
    req_op       = 2'b00;
    req_pc       = 32'h1357_9BDF;
    cp0_index    = 32'h0000_000E;
    cp0_entryhi  = 32'hDEAD_BEEF;
    cp0_entrylo0 = 32'hCAFE_F00D;
    cp0_entrylo1 = 32'h0BAD_CAFE;
    #1;
  endtask

  initial begin
    resetn = 1'b0; req_valid = 1'b0; req_op = 2'b00;
    req_pc = '0; flush = 1'b0; cp0_index = '0;
    cp0_entryhi = '0; cp0_entrylo0 = '0; cp0_entrylo1 = '0;
    s1_found = 1'b0; s1_index = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_tlb_we", tlb_we, 0);
    chk("rst_cancel", cancel, 0);
    chk("rst_cancel_pc", cancel_pc, 0);
    chk("rst_tlbp_p", cp0_tlbp_p, 0);
    chk("rst_w_entry", tlb_w_entry, 0);
    chk("rst_tlbr_data", cp0_tlbr_data, 0);
    resetn = 1'b1;
    tick();

    // op 00 is ignored
    issue(2'b00, 32'h100);
    tick();
    req_valid = 1'b0;
    #1;
    chk("nop_busy", busy, 0);

    // TLBWI
    cp0_index = 32'd5; cp0_entryhi = 32'h0040_2012;
    cp0_entrylo0 = 32'h0000_1047; cp0_entrylo1 = 32'h0000_1087;
    issue(2'b11, 32'h8000_1000);
    chk("wi_ready", req_ready, 1);
    tick();
    scramble();
    chk("wi_we", tlb_we, 1);
    chk("wi_index", tlb_w_index, 5);
    chk("wi_entry", tlb_w_entry, W1);
    chk("wi_g", tlb_w_entry[50], 1);
    chk("wi_pfn0", tlb_w_entry[49:30], 20'h41);
    chk("wi_busy", busy, 1);
    tick();
    chk("wi_we_t2", tlb_we, 0);
    chk("wi_tlbp_we_t2", cp0_tlbp_we, 0);
    chk("wi_tlbr_we_t2", cp0_tlbr_we, 0);
    chk("wi_cancel_t2", cancel, 0);
    tick();
    chk("wi_cancel", cancel, 1);
    chk("wi_cancel_pc", cancel_pc, 32'h8000_1004);
    chk("wi_ready_t3", req_ready, 0);
    tick();
    chk("wi_cancel_t4", cancel, 0);
    chk("wi_ready_t4", req_ready, 1);
    chk("wi_busy_t4", busy, 0);

    // TLBP hit
    cp0_entryhi = 32'h1234_A0FF;
    s1_found = 1'b1; s1_index = 4'd9;
    issue(2'b01, 32'h200);
    tick();
    scramble();
    chk("p_vpn2", s1_vpn2, 19'h091A5);
    chk("p_asid", s1_asid, 8'hFF);
    chk("p_tlb_we", tlb_we, 0);
    tick();
    s1_found = 1'b0; s1_index = 4'd2;
    #1;
    chk("p_we", cp0_tlbp_we, 1);
    chk("p_p", cp0_tlbp_p, 0);
    chk("p_index", cp0_tlbp_index, 9);
    chk("p_tlbr_we", cp0_tlbr_we, 0);
    tick();
    chk("p_we_t3", cp0_tlbp_we, 0);
    chk("p_cancel_t3", cancel, 0);
    chk("p_ready_t3", req_ready, 1);
    chk("p_index_hold", cp0_tlbp_index, 9);

    // TLBP miss
    s1_found = 1'b0; s1_index = 4'd6;
    issue(2'b01, 32'h300);
    tick();
    scramble();
    tick();
    chk("pm_we", cp0_tlbp_we, 1);
    chk("pm_p", cp0_tlbp_p, 1);
    chk("pm_index", cp0_tlbp_index, 0);
    tick();
    chk("pm_cancel", cancel, 0);

    // TLBR
    cp0_index = 32'd3;
    issue(2'b10, 32'h0040_0100);
    tick();
    chk("r_index", tlb_r_index, 3);
    scramble();
    tick();
    chk("r_we", cp0_tlbr_we, 1);
    chk("r_data", cp0_tlbr_data, PAT);
    tick();
    chk("r_cancel", cancel, 1);
    chk("r_cancel_pc", cancel_pc, 32'h0040_0104);
    chk("r_we_t3", cp0_tlbr_we, 0);
    tick();
    chk("r_cancel_t4", cancel, 0);
    chk("r_data_hold", cp0_tlbr_data, PAT);

    // flush in EXEC of TLBWI
    cp0_index = 32'd5;
    issue(2'b11, 32'h500);
    tick();
    scramble();
    flush = 1'b1;
    #1;
    chk("fl_we", tlb_we, 0);
    chk("fl_ready_flush", req_ready, 0);
    tick();
    flush = 1'b0;
    #1;
    chk("fl_busy", busy, 0);
    chk("fl_ready", req_ready, 1);
    chk("fl_cancel", cancel, 0);
    tick();
    chk("fl_cancel_t3", cancel, 0);

    // reset in COMMIT of TLBP
    s1_found = 1'b1; s1_index = 4'd9;
    issue(2'b01, 32'h600);
    tick();
    scramble();
    tick();
    chk("rc_we_before", cp0_tlbp_we, 1);
    resetn = 1'b0;
    #1;
    chk("rc_we_drop", cp0_tlbp_we, 0);
    chk("rc_busy", busy, 0);
    chk("rc_index", cp0_tlbp_index, 0);
    chk("rc_cancel_pc", cancel_pc, 0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    chk("rc_after_we", cp0_tlbp_we, 0);
    chk("rc_after_cancel", cancel, 0);
    chk("rc_after_busy", busy, 0);

    // TLBWI with PC wraparound and index truncation
    cp0_index = 32'h0000_001F; cp0_entryhi = 32'hFFFF_E0FF;
    cp0_entrylo0 = 32'h03FF_FFFC; cp0_entrylo1 = 32'h0000_002B;
    issue(2'b11, 32'hFFFF_FFFC);
    tick();
    scramble();
    chk("wr_we", tlb_we, 1);
    chk("wr_index", tlb_w_index, 4'hF);
    chk("wr_entry", tlb_w_entry, W2);
    tick();
    tick();
    chk("wr_cancel", cancel, 1);
    chk("wr_cancel_pc", cancel_pc, 32'h0000_0000);
    tick();
    chk("wr_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
